// File: rtl/ncc_pkg.sv
// Shared sizing constants and FSM state type for the NCC descriptor loader.
package ncc_pkg;

  localparam int unsigned NUM_ROWS       = 16;
  localparam int unsigned GROUPS_PER_ROW = 4;
  localparam int unsigned WORDS_PER_DESC = NUM_ROWS * GROUPS_PER_ROW;
  localparam int unsigned PIXEL_W        = 8;
  localparam int unsigned WORD_W         = 4 * PIXEL_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } desc_ld_state_t;

endpackage

// File: rtl/ncc_desc_addr_gen.sv
// Row/group word counters for descriptor loading, with one-hot decode and
// a terminal-count flag on the last word of the descriptor.
module ncc_desc_addr_gen #(
  parameter int unsigned NUM_ROWS       = 16,
  parameter int unsigned GROUPS_PER_ROW = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      inc,
  output logic [NUM_ROWS-1:0]       row_oh,
  output logic [GROUPS_PER_ROW-1:0] grp_oh,
  output logic                      tc
);

  localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int unsigned GRP_W = (GROUPS_PER_ROW > 1) ? $clog2(GROUPS_PER_ROW) : 1;

  logic [ROW_W-1:0] row_q, row_d;
  logic [GRP_W-1:0] grp_q, grp_d;

  // Next-count: clear wins over increment; group wrap carries into row.
  always_comb begin
    row_d = row_q;
    grp_d = grp_q;
    if (clr) begin
      row_d = '0;
      grp_d = '0;
    end else if (inc) begin
      if (grp_q == GRP_W'(GROUPS_PER_ROW - 1)) begin
        grp_d = '0;
        row_d = (row_q == ROW_W'(NUM_ROWS - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        grp_d = grp_q + GRP_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      grp_q <= '0;
    end else begin
      row_q <= row_d;
      grp_q <= grp_d;
    end
  end

  // One-hot decode of the current position and last-word flag.
  always_comb begin
    row_oh         = '0;
    grp_oh         = '0;
    row_oh[row_q]  = 1'b1;
    grp_oh[grp_q]  = 1'b1;
    tc = (row_q == ROW_W'(NUM_ROWS - 1)) && (grp_q == GRP_W'(GROUPS_PER_ROW - 1));
  end

endmodule

// File: rtl/ncc_desc_loader.sv
// Descriptor load sequencer: takes a framed word stream and drives registered
// one-hot row/group load enables and data into the NCC PE grid.
module ncc_desc_loader #(
  parameter int unsigned NUM_ROWS       = ncc_pkg::NUM_ROWS,
  parameter int unsigned GROUPS_PER_ROW = ncc_pkg::GROUPS_PER_ROW,
  parameter int unsigned WORD_W         = ncc_pkg::WORD_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      desc_valid,
  input  logic [WORD_W-1:0]         desc_data,
  input  logic                      desc_last,
  output logic                      desc_ready,
  output logic                      load_en,
  output logic [NUM_ROWS-1:0]       load_row,
  output logic [GROUPS_PER_ROW-1:0] load_group,
  output logic [WORD_W-1:0]         load_data,
  output logic                      busy,
  output logic                      done,
  output logic                      desc_loaded,
  output logic                      err
);

  import ncc_pkg::*;

  desc_ld_state_t              state_q, state_d;
  logic                        load_en_q, load_en_d;
  logic [NUM_ROWS-1:0]         load_row_q, load_row_d;
  logic [GROUPS_PER_ROW-1:0]   load_group_q, load_group_d;
  logic [WORD_W-1:0]           load_data_q, load_data_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        desc_loaded_q, desc_loaded_d;
  logic                        err_q, err_d;

  logic                        ctr_clr, ctr_inc, ctr_tc;
  logic [NUM_ROWS-1:0]         row_oh;
  logic [GROUPS_PER_ROW-1:0]   grp_oh;

  ncc_desc_addr_gen #(
    .NUM_ROWS       (NUM_ROWS),
    .GROUPS_PER_ROW (GROUPS_PER_ROW)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (ctr_clr),
    .inc    (ctr_inc),
    .row_oh (row_oh),
    .grp_oh (grp_oh),
    .tc     (ctr_tc)
  );

  assign desc_ready = (state_q == ST_LOAD);

  // Next-state and registered-output decode; row/group/data hold between loads.
  always_comb begin
    state_d       = state_q;
    load_en_d     = 1'b0;
    load_row_d    = load_row_q;
    load_group_d  = load_group_q;
    load_data_d   = load_data_q;
    done_d        = 1'b0;
    desc_loaded_d = desc_loaded_q;
    err_d         = err_q;
    ctr_clr       = 1'b0;
    ctr_inc       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_LOAD;
          ctr_clr       = 1'b1;
          err_d         = 1'b0;
          desc_loaded_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (desc_valid) begin
          load_en_d    = 1'b1;
          load_row_d   = row_oh;
          load_group_d = grp_oh;
          load_data_d  = desc_data;
          ctr_inc      = 1'b1;
          if (ctr_tc) begin
            // Full word count reached: data is complete even if framing is wrong.
            state_d = ST_DONE;
            done_d  = 1'b1;
            if (!desc_last) err_d = 1'b1;
          end else if (desc_last) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        desc_loaded_d = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      load_en_q     <= 1'b0;
      load_row_q    <= '0;
      load_group_q  <= '0;
      load_data_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      desc_loaded_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_en_q     <= load_en_d;
      load_row_q    <= load_row_d;
      load_group_q  <= load_group_d;
      load_data_q   <= load_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      desc_loaded_q <= desc_loaded_d;
      err_q         <= err_d;
    end
  end

  assign load_en     = load_en_q;
  assign load_row    = load_row_q;
  assign load_group  = load_group_q;
  assign load_data   = load_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign desc_loaded = desc_loaded_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ncc_desc_loader.sv
// Self-checking bench for ncc_desc_loader: directed vector table, hand
// sequences for frame corner cases, and randomized traffic against a
// word-count based reference model.
module tb_ncc_desc_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        desc_valid;
  logic [31:0] desc_data;
  logic        desc_last;
  logic        desc_ready;
  logic        load_en;
  logic [15:0] load_row;
  logic [3:0]  load_group;
  logic [31:0] load_data;
  logic        busy;
  logic        done;
  logic        desc_loaded;
  logic        err;

  ncc_desc_loader #(
    .NUM_ROWS       (16),
    .GROUPS_PER_ROW (4),
    .WORD_W         (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .desc_valid  (desc_valid),
    .desc_data   (desc_data),
    .desc_last   (desc_last),
    .desc_ready  (desc_ready),
    .load_en     (load_en),
    .load_row    (load_row),
    .load_group  (load_group),
    .load_data   (load_data),
    .busy        (busy),
    .done        (done),
    .desc_loaded (desc_loaded),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: word count within the frame plus completion/error flags.
  bit          m_active, m_donep, m_err, m_loaded, m_en, m_done;
  int          m_idx;
  logic [15:0] m_row;
  logic [3:0]  m_grp;
  logic [31:0] m_data;

  int en_cnt, done_cnt;

  typedef struct {
    bit          s, v, l;
    logic [31:0] d;
    bit          e_en;
    logic [15:0] e_row;
    logic [3:0]  e_grp;
    bit          e_busy, e_err, e_ready;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_donep = 0; m_err = 0; m_loaded = 0;
    m_en = 0; m_done = 0; m_idx = 0;
  endtask

  task automatic model_step(input bit s, input bit v, input bit l, input logic [31:0] d);
    m_en   = 0;
    m_done = 0;
    if (m_donep) begin
      m_donep  = 0;
      m_loaded = 1;
    end else if (!m_active) begin
      if (s) begin
        m_active = 1; m_idx = 0; m_err = 0; m_loaded = 0;
      end
    end else if (v) begin
      m_en   = 1;
      m_row  = 16'(1) << (m_idx / 4);
      m_grp  = 4'(1) << (m_idx % 4);
      m_data = d;
      if (m_idx == 63) begin
        m_active = 0; m_donep = 1; m_done = 1;
        if (!l) m_err = 1;
      end else if (l) begin
        m_active = 0; m_err = 1;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/load_en"}, 32'(load_en), 32'(m_en));
    chk({tag, "/done"}, 32'(done), 32'(m_done));
    chk({tag, "/busy"}, 32'(busy), 32'(m_active | m_donep));
    chk({tag, "/desc_loaded"}, 32'(desc_loaded), 32'(m_loaded));
    chk({tag, "/err"}, 32'(err), 32'(m_err));
    chk({tag, "/desc_ready"}, 32'(desc_ready), 32'(m_active));
    if (m_en) begin
      chk({tag, "/load_row"}, 32'(load_row), 32'(m_row));
      chk({tag, "/load_group"}, 32'(load_group), 32'(m_grp));
      chk({tag, "/load_data"}, load_data, m_data);
    end
  endtask

  task automatic cyc(input string tag, input bit s, input bit v, input bit l, input logic [31:0] d);
    start = s; desc_valid = v; desc_last = l; desc_data = d;
    @(posedge clk);
    model_step(s, v, l, d);
    #1;
    check_all(tag);
    if (load_en) en_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "/load_en"}, 32'(load_en), 0);
    chk({tag, "/load_row"}, 32'(load_row), 0);
    chk({tag, "/load_group"}, 32'(load_group), 0);
    chk({tag, "/load_data"}, load_data, 0);
    chk({tag, "/busy"}, 32'(busy), 0);
    chk({tag, "/done"}, 32'(done), 0);
    chk({tag, "/desc_loaded"}, 32'(desc_loaded), 0);
    chk({tag, "/err"}, 32'(err), 0);
    chk({tag, "/desc_ready"}, 32'(desc_ready), 0);
  endtask

  // Asynchronous reset applied away from the clock edge.
  task automatic mid_reset(input string tag);
    rst = 1'b1;
    #1;
    chk_zero(tag);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One start cycle followed by n_words words; gap inserts an idle cycle
  // between words; ncyc is first-word to last-word cycle span.
  task automatic run_frame(input string tag, input int n_words, input bit last_on_final,
                           input bit gap, input bit poke_start, output int ncyc);
    en_cnt = 0; done_cnt = 0; ncyc = 0;
    cyc({tag, "/start"}, 1, 0, 0, 0);
    for (int i = 0; i < n_words; i++) begin
      if (gap && i != 0) begin
        cyc({tag, "/gap"}, poke_start, 0, 0, 32'hDEAD_BEEF);
        ncyc++;
      end
      cyc({tag, "/word"}, poke_start && (i % 7 == 3), 1,
          (i == n_words - 1) ? last_on_final : 1'b0, 32'h0001_0203 + 32'(i));
      ncyc++;
      if (i == 5) begin
        chk({tag, "/w5_row"}, 32'(load_row), 32'h0002);
        chk({tag, "/w5_group"}, 32'(load_group), 32'b0010);
      end
    end
    cyc({tag, "/tail0"}, 0, 0, 0, 0);
    cyc({tag, "/tail1"}, 0, 0, 0, 0);
  endtask

  initial begin
    int ncyc;
    rst = 1'b1; start = 0; desc_valid = 0; desc_data = '0; desc_last = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed table: idle-valid ignored, stall, start in LOAD ignored, early last.
    //            s  v  l  data          en row      grp   busy err ready
    tbl[0]  = '{0, 1, 0, 32'h1111_1111, 0, 16'h0000, 4'h0, 0,   0,  0};
    tbl[1]  = '{1, 1, 0, 32'h2222_2222, 0, 16'h0000, 4'h0, 1,   0,  1};
    tbl[2]  = '{0, 1, 0, 32'hA000_0000, 1, 16'h0001, 4'h1, 1,   0,  1};
    tbl[3]  = '{0, 0, 0, 32'h3333_3333, 0, 16'h0000, 4'h0, 1,   0,  1};
    tbl[4]  = '{1, 1, 0, 32'hA000_0001, 1, 16'h0001, 4'h2, 1,   0,  1};
    tbl[5]  = '{0, 1, 0, 32'hA000_0002, 1, 16'h0001, 4'h4, 1,   0,  1};
    tbl[6]  = '{0, 1, 0, 32'hA000_0003, 1, 16'h0001, 4'h8, 1,   0,  1};
    tbl[7]  = '{0, 1, 1, 32'hA000_0004, 1, 16'h0002, 4'h1, 0,   1,  0};
    tbl[8]  = '{0, 1, 0, 32'h4444_4444, 0, 16'h0000, 4'h0, 0,   1,  0};
    tbl[9]  = '{1, 0, 0, 32'h0,         0, 16'h0000, 4'h0, 1,   0,  1};
    tbl[10] = '{0, 1, 0, 32'hB000_0000, 1, 16'h0001, 4'h1, 1,   0,  1};
    for (int i = 0; i < 11; i++) begin
      start = tbl[i].s; desc_valid = tbl[i].v; desc_last = tbl[i].l; desc_data = tbl[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d/load_en", i), 32'(load_en), 32'(tbl[i].e_en));
      chk($sformatf("tbl%0d/busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d/err", i), 32'(err), 32'(tbl[i].e_err));
      chk($sformatf("tbl%0d/desc_ready", i), 32'(desc_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d/done", i), 32'(done), 0);
      if (tbl[i].e_en) begin
        chk($sformatf("tbl%0d/load_row", i), 32'(load_row), 32'(tbl[i].e_row));
        chk($sformatf("tbl%0d/load_group", i), 32'(load_group), 32'(tbl[i].e_grp));
        chk($sformatf("tbl%0d/load_data", i), load_data, tbl[i].d);
      end
    end
    mid_reset("tbl_rst");

    // Back-to-back full frame.
    run_frame("b2b", 64, 1, 0, 0, ncyc);
    chk("b2b/en_cnt", 32'(en_cnt), 64);
    chk("b2b/done_cnt", 32'(done_cnt), 1);
    chk("b2b/ncyc", 32'(ncyc), 64);
    chk("b2b/desc_loaded", 32'(desc_loaded), 1);
    chk("b2b/err", 32'(err), 0);

    // Valid toggled every other cycle.
    run_frame("gap", 64, 1, 1, 0, ncyc);
    chk("gap/en_cnt", 32'(en_cnt), 64);
    chk("gap/done_cnt", 32'(done_cnt), 1);
    chk("gap/ncyc", 32'(ncyc), 127);

    // Early last on word 10, then a new start clears err.
    run_frame("early", 11, 1, 0, 0, ncyc);
    chk("early/en_cnt", 32'(en_cnt), 11);
    chk("early/done_cnt", 32'(done_cnt), 0);
    chk("early/err", 32'(err), 1);
    chk("early/desc_loaded", 32'(desc_loaded), 0);
    chk("early/busy", 32'(busy), 0);
    cyc("early/restart", 1, 0, 0, 0);
    chk("early/err_clr", 32'(err), 0);
    cyc("early/w0", 0, 1, 0, 32'h5555_0000);
    chk("early/w0_row", 32'(load_row), 32'h0001);
    mid_reset("early_rst");

    // Word 63 without last, with start pokes during LOAD.
    run_frame("nolast", 64, 0, 0, 1, ncyc);
    chk("nolast/en_cnt", 32'(en_cnt), 64);
    chk("nolast/done_cnt", 32'(done_cnt), 1);
    chk("nolast/desc_loaded", 32'(desc_loaded), 1);
    chk("nolast/err", 32'(err), 1);

    // Async reset after word 30, then a clean full frame.
    cyc("rst/start", 1, 0, 0, 0);
    for (int i = 0; i <= 30; i++) cyc("rst/word", 0, 1, 0, 32'(i));
    mid_reset("rst_mid");
    cyc("rst/start2", 1, 0, 0, 0);
    cyc("rst/w0", 0, 1, 0, 32'h7777_0000);
    chk("rst/w0_row", 32'(load_row), 32'h0001);
    chk("rst/w0_group", 32'(load_group), 32'b0001);
    for (int i = 1; i < 64; i++) cyc("rst/word2", 0, 1, i == 63, 32'h7777_0000 + 32'(i));
    cyc("rst/tail", 0, 0, 0, 0);
    chk("rst/desc_loaded", 32'(desc_loaded), 1);

    // Valid in IDLE without start consumes nothing.
    en_cnt = 0;
    for (int i = 0; i < 5; i++) cyc("idle_v", 0, 1, 0, 32'hCAFE_0000 + 32'(i));
    chk("idle_v/en_cnt", 32'(en_cnt), 0);
    cyc("idle_v/start", 1, 0, 0, 0);
    cyc("idle_v/w0", 0, 1, 0, 32'hCAFE_1000);
    mid_reset("idle_rst");

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bit s, v, l;
      s = ($urandom % 16) == 0;
      v = ($urandom % 3) != 0;
      l = (m_idx == 63) ? (($urandom % 4) != 0) : (($urandom % 64) == 0);
      if (($urandom % 1500) == 0) mid_reset("rand_rst");
      else cyc("rand", s, v, l, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
